// File: rtl/ff_conv_bist_ctrl_if.sv
// Signal bundle between the flip-flop BIST sequencer and its environment.
// The master side is the sequencer and the slave side is the FF/test harness.
interface ff_conv_bist_ctrl_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic [1:0]       mode;
    logic             ff_a;
    logic             ff_b;
    logic             ff_rst;
    logic             ff_q;
    logic             ff_qb;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;

    modport master (
        input  start, mode, ff_q, ff_qb,
        output ff_a, ff_b, ff_rst, busy, done, pass, err_count
    );

    modport slave (
        output start, mode, ff_q, ff_qb,
        input  ff_a, ff_b, ff_rst, busy, done, pass, err_count
    );
endinterface

// File: rtl/ff_conv_bist_ctrl.sv
// BIST sequencer for one converted flip-flop (JK/SR/D/T).
// Drives vectors, tracks a golden q and counts q/qb mismatches.
module ff_conv_bist_ctrl #(
    parameter int N_PASSES   = 2,
    parameter int RST_CYCLES = 2,
    parameter int ERR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ff_conv_bist_ctrl_if.master  bus
);
    localparam int PW = $clog2(N_PASSES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] M_JK = 2'd0;
    localparam logic [1:0] M_SR = 2'd1;
    localparam logic [1:0] M_D  = 2'd2;
    localparam logic [1:0] M_T  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        APPLY,
        CHECK,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] mode_q;
    logic [1:0] v;
    logic [PW-1:0] pidx;
    logic [RW-1:0] rcnt;
    logic       exp_q;

    logic       exp_nxt;
    logic [1:0] last_v;
    logic [1:0] v_nxt;
    logic       mism;
    logic [ERR_W-1:0] err_nxt;

    function automatic logic vec_a(input logic [1:0] m, input logic [1:0] vv);
        return (m == M_JK || m == M_SR) ? vv[1] : vv[0];
    endfunction

    function automatic logic vec_b(input logic [1:0] m, input logic [1:0] vv);
        return (m == M_JK || m == M_SR) ? vv[0] : 1'b0;
    endfunction

    // SR skips v=3 so the forbidden S=R=1 is never applied
    assign last_v = (mode_q == M_SR) ? 2'd2 : 2'd3;
    assign v_nxt  = (v == last_v) ? 2'd0 : v + 2'd1;
    assign mism   = (bus.ff_q != exp_q) | (bus.ff_qb != ~exp_q);
    assign err_nxt = bus.err_count
                   + ERR_W'(mism && (bus.err_count != '1));

    always_comb begin
        exp_nxt = exp_q;
        unique case (mode_q)
            M_JK: begin
                unique case ({bus.ff_a, bus.ff_b})
                    2'b01:   exp_nxt = 1'b0;
                    2'b10:   exp_nxt = 1'b1;
                    2'b11:   exp_nxt = ~exp_q;
                    default: exp_nxt = exp_q;
                endcase
            end
            M_SR: begin
                unique case ({bus.ff_a, bus.ff_b})
                    2'b01:   exp_nxt = 1'b0;
                    2'b10:   exp_nxt = 1'b1;
                    default: exp_nxt = exp_q;
                endcase
            end
            M_D:     exp_nxt = bus.ff_a;
            M_T:     exp_nxt = bus.ff_a ? ~exp_q : exp_q;
            default: exp_nxt = exp_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= M_JK;
            v             <= 2'd0;
            pidx          <= '0;
            rcnt          <= '0;
            exp_q         <= 1'b0;
            bus.ff_a      <= 1'b0;
            bus.ff_b      <= 1'b0;
            bus.ff_rst    <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.ff_rst <= 1'b1;
                    bus.ff_a   <= 1'b0;
                    bus.ff_b   <= 1'b0;
                    if (bus.start) begin
                        mode_q        <= bus.mode;
                        bus.err_count <= '0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                        rcnt          <= '0;
                        exp_q         <= 1'b0;
                        v             <= 2'd0;
                        pidx          <= '0;
                        state         <= RST;
                    end
                end
                RST: begin
                    if (rcnt == RW'(RST_CYCLES - 1)) begin
                        bus.ff_rst <= 1'b0;
                        bus.ff_a   <= vec_a(mode_q, 2'd0);
                        bus.ff_b   <= vec_b(mode_q, 2'd0);
                        state      <= APPLY;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                APPLY: begin
                    exp_q <= exp_nxt;
                    state <= CHECK;
                end
                CHECK: begin
                    bus.err_count <= err_nxt;
                    v             <= v_nxt;
                    if (v == last_v && pidx == PW'(N_PASSES - 1)) begin
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.pass   <= (err_nxt == '0);
                        bus.ff_rst <= 1'b1;
                        bus.ff_a   <= 1'b0;
                        bus.ff_b   <= 1'b0;
                        state      <= DONE;
                    end else begin
                        if (v == last_v) pidx <= pidx + PW'(1);
                        bus.ff_a <= vec_a(mode_q, v_nxt);
                        bus.ff_b <= vec_b(mode_q, v_nxt);
                        state    <= APPLY;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
